// File: rtl/natv_bus_pkg.sv
// Shared types and constants for the native valid/ready bus demultiplexer.
package natv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DERR   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0]  ERR_NONE      = 2'b00;
  localparam logic [1:0]  ERR_DEC       = 2'b01;
  localparam logic [1:0]  ERR_TO        = 2'b10;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/natv_bus_if.sv
// Native memory bus bundle: core request/response plus broadcast slave side.
interface natv_bus_if #(
  parameter int NUM_SLV = 4
);
  logic                   core_valid_i;
  logic                   core_ready_o;
  logic [31:0]            core_addr_i;
  logic [31:0]            core_wdata_i;
  logic [3:0]             core_wstrb_i;
  logic [31:0]            core_rdata_o;
  logic [NUM_SLV-1:0]     slv_valid_o;
  logic [NUM_SLV-1:0]     slv_ready_i;
  logic [31:0]            slv_addr_o;
  logic [31:0]            slv_wdata_o;
  logic [3:0]             slv_wstrb_o;
  logic [NUM_SLV*32-1:0]  slv_rdata_i;

  // slave = the demux itself; master = core plus the peripheral environment
  modport slave (
    input  core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
    input  slv_ready_i, slv_rdata_i,
    output core_ready_o, core_rdata_o,
    output slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o
  );

  modport master (
    output core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
    output slv_ready_i, slv_rdata_i,
    input  core_ready_o, core_rdata_o,
    input  slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o
  );
endinterface

// File: rtl/natv_bus_dec.sv
// Combinational address decoder; on overlapping windows the lowest slot wins.
module natv_bus_dec #(
  parameter int                    NUM_SLV  = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = '0
) (
  input  logic [31:0]        i_addr,
  output logic               o_hit,
  output logic [NUM_SLV-1:0] o_sel
);

  // Walk from the top so a lower-index hit overrides any higher one.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((i_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        o_hit    = 1'b1;
        o_sel    = '0;
        o_sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/natv_bus_demux.sv
// 1-master / NUM_SLV-slave native bus interconnect with registered request path.
// Optional slave-hang timeout: define NATV_BUS_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | waiting for core_valid_i, decode on the fly
//   ACCESS | one-hot slave request outstanding
//   DERR   | unmapped address, build error response
//   RESP   | one-cycle core_ready_o strobe
module natv_bus_demux
  import natv_bus_pkg::*;
#(
  parameter int                    NUM_SLV     = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {32'h4000_0000, 32'h3000_0000,
                                                  32'h0300_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {32'hFF00_0000, 32'hFF00_0000,
                                                  32'hFFFF_0000, 32'hFFFE_0000},
  parameter logic [31:0]           ERR_RDATA   = ERR_RDATA_DEF,
  parameter int                    TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  natv_bus_if.slave   bus,
  input  logic        err_clr_i,
  output logic        err_irq_o,
  output logic [1:0]  err_type_o,
  output logic [31:0] err_addr_o
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("natv_bus_demux: TIMEOUT_CYC must be >= 2");
  end

  state_t               r_state;
  logic [NUM_SLV-1:0]   r_sel;
  logic [NUM_SLV-1:0]   r_slv_valid;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [31:0]          r_rdata;
  logic                 r_core_ready;
  logic                 r_err_irq;
  logic [1:0]           r_err_type;
  logic [31:0]          r_err_addr;

  logic                 w_hit;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic                 w_err_dec;
  logic                 w_err_to;
  logic                 w_err_evt;
  logic [1:0]           w_err_type;

  natv_bus_dec #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .i_addr (bus.core_addr_i),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  assign w_sel_ready = |(bus.slv_ready_i & r_sel);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_sel[i]) w_sel_rdata = w_sel_rdata | bus.slv_rdata_i[32*i +: 32];
    end
  end

`ifdef NATV_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  // Ready arriving on the terminal count wins over the timeout.
  assign w_err_to = (r_state == ST_ACCESS) && !w_sel_ready && w_to_hit;
`else
  assign w_err_to = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_slv_valid  <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rdata      <= '0;
      r_core_ready <= 1'b0;
`ifdef NATV_BUS_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_core_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.core_valid_i) begin
            r_addr <= bus.core_addr_i;
            if (w_hit) begin
              r_wdata     <= bus.core_wdata_i;
              r_wstrb     <= bus.core_wstrb_i;
              r_sel       <= w_sel;
              r_slv_valid <= w_sel;
`ifdef NATV_BUS_TIMEOUT_EN
              r_to_cnt    <= '0;
`endif
              r_state     <= ST_ACCESS;
            end else begin
              r_state <= ST_DERR;
            end
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            r_rdata      <= w_sel_rdata;
            r_slv_valid  <= '0;
            r_core_ready <= 1'b1;
            r_state      <= ST_RESP;
          end
`ifdef NATV_BUS_TIMEOUT_EN
          else if (w_to_hit) begin
            r_rdata      <= ERR_RDATA;
            r_slv_valid  <= '0;
            r_core_ready <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_DERR: begin
          r_rdata      <= ERR_RDATA;
          r_core_ready <= 1'b1;
          r_state      <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_err_dec  = (r_state == ST_DERR);
  assign w_err_evt  = w_err_dec || w_err_to;
  assign w_err_type = w_err_dec ? ERR_DEC : ERR_TO;

  // A new error in the same cycle as err_clr_i is captured, not lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_irq  <= 1'b0;
      r_err_type <= ERR_NONE;
      r_err_addr <= '0;
    end else if (w_err_evt && (!r_err_irq || err_clr_i)) begin
      r_err_irq  <= 1'b1;
      r_err_type <= w_err_type;
      r_err_addr <= r_addr;
    end else if (err_clr_i) begin
      r_err_irq  <= 1'b0;
      r_err_type <= ERR_NONE;
      r_err_addr <= '0;
    end
  end

  assign bus.core_ready_o = r_core_ready;
  assign bus.core_rdata_o = r_rdata;
  assign bus.slv_valid_o  = r_slv_valid;
  assign bus.slv_addr_o   = r_addr;
  assign bus.slv_wdata_o  = r_wdata;
  assign bus.slv_wstrb_o  = r_wstrb;
  assign err_irq_o        = r_err_irq;
  assign err_type_o       = r_err_type;
  assign err_addr_o       = r_err_addr;

endmodule
